tokenflow_sequencer: RTL and testbench
======================================

Name: tokenflow_sequencer

Overview:
- Clocked controller that consumes the token stream of the asynchronous `tokenflow` bundled-data channel from the synchronous side.
- Runs a bounded burst of 4-phase handshakes on the channel.
- Captures each data token and checks it against the reference sequence 0, 2, 6, 12, … x*(x+1).
- Reports count, mismatch and handshake-timeout status to the rest of the tile.

Parameters:
- W, 26, channel data width (matches the tokenflow instance width).
- SYNC, 2, number of flops in the ch_req synchronizer (minimum 2).
- TW, 16, width of the timeout counter and of timeout_limit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE or DONE
- burst_len  in  16  tokens per burst; 0 = unlimited
- check_en  in  1  enable comparison against the x*(x+1) sequence
- timeout_limit  in  TW  max cycles waiting on one handshake phase; 0 = disabled
- ch_req  in  1  channel request from tokenflow (asynchronous to clk)
- ch_data  in  W  channel data; stable whenever ch_req is high (bundled-data)
- ch_ack  out  1  channel acknowledge to tokenflow
- tok_valid  out  1  one-cycle pulse: tok_data holds a new token
- tok_data  out  W  last captured token
- tok_count  out  16  tokens captured in the current burst
- busy  out  1  high in WAIT_REQ and WAIT_REL
- done  out  1  high in DONE
- mismatch  out  1  sticky: a checked token differed from expected
- timeout  out  1  sticky: a handshake phase exceeded timeout_limit

Behaviour:
- Reset values (asynchronous): all outputs 0; synchronizer 0; state IDLE; expected value exp=0; increment inc=2; timeout counter 0.
- Synchronizer: req_s is ch_req after SYNC flops. ch_data is never synchronized; it is sampled only while req_s=1.
- FSM states: IDLE, WAIT_REQ, WAIT_REL, DONE.
- IDLE/DONE with start=1:
  - clear tok_count, mismatch, timeout; exp<=0, inc<=2.
  - go to WAIT_REQ; done drops the next cycle.
- WAIT_REQ with req_s=1 (same edge):
  - tok_data<=ch_data, tok_valid<=1, ch_ack<=1, tok_count+=1 (wraps at 2^16).
  - if check_en and ch_data!=exp: mismatch<=1.
  - exp<=exp+inc, inc<=inc+2; both mod 2^W, advanced regardless of check_en.
  - go to WAIT_REL.
- tok_valid is high for exactly one cycle per token.
- WAIT_REL with req_s=0:
  - ch_ack<=0.
  - if burst_len!=0 and tok_count==burst_len: go to DONE, else WAIT_REQ.
- Full 4-phase protocol: ack never falls while req_s=1 except on timeout or reset. A new token is never accepted before the previous ack has fallen.
- Latency: ch_req rise to ch_ack rise = SYNC+1 clk edges. The same holds for ch_req fall to ch_ack fall.
- Timeout:
  - counter clears on every state change and counts each cycle in WAIT_REQ or WAIT_REL.
  - if timeout_limit!=0 and counter==timeout_limit-1 while still waiting: timeout<=1, ch_ack<=0, go to DONE.
  - the token in flight is not counted again.
- start while busy: ignored.
- start and the final req_s fall on the same edge: go to DONE; start is not sampled that cycle.
- burst_len changes mid-burst: take effect at the next WAIT_REL comparison. A value below tok_count gives an unbounded burst until tok_count wraps to match.
- Reset mid-handshake: ch_ack drops immediately (asynchronously); tokenflow sees the release.

Test Plan:
- Loopback (ch_req driven from ch_ack through a 3-cycle delay, data=x*(x+1) model), burst_len=5, check_en=1 -> tok_data 0,2,6,12,20 with five tok_valid pulses; tok_count=5; done=1; mismatch=0; ch_ack=0.
- Same stream with token 3 corrupted to 13 -> mismatch=1 from the capture edge of token 3; burst still completes with tok_count=5.
- ch_req raised, never released, timeout_limit=8 -> ch_ack rises SYNC+1 edges after req; timeout=1 after 8 cycles in WAIT_REL; DONE; ch_ack=0; tok_count=1.
- ch_req held at 0, timeout_limit=0, burst_len=1 -> stays in WAIT_REQ forever with busy=1; start pulses ignored.
- Async reset asserted mid-WAIT_REL -> ch_ack=0 and all outputs 0 without a clock edge; after release and start, exp restarts at 0.
- burst_len=0 with 300 tokens -> never DONE; tok_count=300; token 299 checks as 299*300=89700.

Source files
------------

// File: rtl/tokenflow_sequencer.sv
// tokenflow_sequencer: clocked consumer for the asynchronous tokenflow
// bundled-data channel. It runs a bounded burst of 4-phase handshakes,
// captures every data token and checks it against x*(x+1). Count,
// mismatch and handshake-timeout status are reported to the tile.
//
// Channel handshake (4-phase, return-to-zero):
//   ch_req rises with ch_data already stable; data stays stable while
//   ch_req is high. Once the synchronized request (req_s) is seen, the
//   token is captured and ch_ack rises. ch_req then falls, and once that
//   fall is seen ch_ack falls. A new token is taken only after ch_ack has
//   fallen. ch_ack only drops early on a timeout or on reset.
module tokenflow_sequencer #(
  parameter int W    = 26,
  parameter int SYNC = 2,
  parameter int TW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   burst_len,
  input  logic          check_en,
  input  logic [TW-1:0] timeout_limit,
  input  logic          ch_req,
  input  logic [W-1:0]  ch_data,
  output logic          ch_ack,
  output logic          tok_valid,
  output logic [W-1:0]  tok_data,
  output logic [15:0]   tok_count,
  output logic          busy,
  output logic          done,
  output logic          mismatch,
  output logic          timeout,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    WAIT_REL = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [W-1:0]  EXP_INIT = '0;
  localparam logic [W-1:0]  INC_INIT = W'(2);
  localparam logic [W-1:0]  INC_STEP = W'(2);
  localparam logic [TW-1:0] TW_ONE   = TW'(1);
  localparam logic [15:0]   CNT_ONE  = 16'd1;

  state_t          state;
  logic [SYNC-1:0] req_sync;
  logic            req_s;
  logic [W-1:0]    exp_val;
  logic [W-1:0]    inc_val;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;

  assign req_s     = req_sync[SYNC-1];
  assign dbg_state = state;

  // The current wait phase has used up its cycle budget (0 disables).
  assign tmo_hit = (timeout_limit != '0) && (tmo_cnt == (timeout_limit - TW_ONE));

  // Bring the asynchronous channel request into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC-2:0], ch_req};
    end
  end

  // Burst sequencer: handshake FSM, token capture, sequence check, timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ch_ack    <= 1'b0;
      tok_valid <= 1'b0;
      tok_data  <= '0;
      tok_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      exp_val   <= EXP_INIT;
      inc_val   <= INC_INIT;
      tmo_cnt   <= '0;
    end else begin
      tok_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          tmo_cnt <= '0;
          if (start) begin
            tok_count <= '0;
            mismatch  <= 1'b0;
            timeout   <= 1'b0;
            exp_val   <= EXP_INIT;
            inc_val   <= INC_INIT;
            state     <= WAIT_REQ;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        WAIT_REQ: begin
          if (req_s) begin
            // ch_data is bundled with ch_req, so it is stable here.
            tok_data  <= ch_data;
            tok_valid <= 1'b1;
            ch_ack    <= 1'b1;
            tok_count <= tok_count + CNT_ONE;
            if (check_en && (ch_data != exp_val)) begin
              mismatch <= 1'b1;
            end
            // Next x*(x+1) is reached by adding the running even step.
            exp_val <= exp_val + inc_val;
            inc_val <= inc_val + INC_STEP;
            state   <= WAIT_REL;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            ch_ack  <= 1'b0;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW_ONE;
          end
        end

        WAIT_REL: begin
          if (!req_s) begin
            ch_ack  <= 1'b0;
            tmo_cnt <= '0;
            if ((burst_len != '0) && (tok_count == burst_len)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= WAIT_REQ;
            end
          end else if (tmo_hit) begin
            // Abandon the handshake; the token already counted stays counted.
            timeout <= 1'b1;
            ch_ack  <= 1'b0;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tokenflow_sequencer.sv
// Directed bench for tokenflow_sequencer: loopback producer, timeout,
// stuck-wait, asynchronous reset and long unbounded burst scenarios.
module tb_tokenflow_sequencer;

  localparam int W    = 26;
  localparam int SYNC = 2;
  localparam int TW   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   burst_len;
  logic          check_en;
  logic [TW-1:0] timeout_limit;
  logic          ch_req;
  logic [W-1:0]  ch_data;
  logic          ch_ack;
  logic          tok_valid;
  logic [W-1:0]  tok_data;
  logic [15:0]   tok_count;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic          timeout;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic         mm_q[$];

  // loopback producer state
  logic       lb_en = 1'b0;
  logic [2:0] lb_d  = '0;
  int         lb_x  = 0;
  int         lb_max = 0;
  logic       lb_corrupt = 1'b0;

  tokenflow_sequencer #(.W(W), .SYNC(SYNC), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .check_en(check_en), .timeout_limit(timeout_limit), .ch_req(ch_req),
    .ch_data(ch_data), .ch_ack(ch_ack), .tok_valid(tok_valid),
    .tok_data(tok_data), .tok_count(tok_count), .busy(busy), .done(done),
    .mismatch(mismatch), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic lb_setup(input int max_tokens, input logic corrupt);
    lb_en      = 1'b0;
    ch_req     = 1'b0;
    lb_d       = '0;
    lb_x       = 0;
    lb_max     = max_tokens;
    lb_corrupt = corrupt;
  endtask

  task automatic push_exp(input int x, input logic corrupt, input logic mm);
    logic [W-1:0] v;
    v = (corrupt && x == 3) ? W'(13) : W'(x * (x + 1));
    exp_q.push_back(v);
    mm_q.push_back(mm);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  // Loopback producer: ch_req follows ~ch_ack three cycles later.
  always @(negedge clk) begin
    if (lb_en) begin
      logic want;
      lb_d = {lb_d[1:0], ch_ack};
      want = ~lb_d[2];
      if (want && !ch_req) begin
        if (lb_x < lb_max) begin
          ch_data = (lb_corrupt && lb_x == 3) ? W'(13) : W'(lb_x * (lb_x + 1));
          lb_x++;
          ch_req = 1'b1;
        end
      end else if (!want) begin
        ch_req = 1'b0;
      end
    end
  end

  // Scoreboard: every tok_valid pulse is matched with the expected queue.
  always @(negedge clk) begin
    if (tok_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL tok_unexpected observed=%0d expected=none", tok_data);
      end else begin
        logic [W-1:0] e;
        logic         m;
        e = exp_q.pop_front();
        m = mm_q.pop_front();
        chk("tok_data", 32'(tok_data), 32'(e));
        chk("tok_mismatch", {31'd0, mismatch}, {31'd0, m});
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    burst_len = '0;
    check_en = 1'b0;
    timeout_limit = '0;
    ch_req = 1'b0;
    ch_data = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_ack", {31'd0, ch_ack}, 32'd0);
    chk("rst_valid", {31'd0, tok_valid}, 32'd0);
    chk("rst_data", 32'(tok_data), 32'd0);
    chk("rst_count", 32'(tok_count), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: loopback burst of 5 clean tokens
    lb_setup(5, 1'b0);
    burst_len = 16'd5;
    check_en = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(i, 1'b0, 1'b0);
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_done_low", {31'd0, done}, 32'd0);
    lb_en = 1'b1;
    wait_done(400);
    chk("t1_count", 32'(tok_count), 32'd5);
    chk("t1_last", 32'(tok_data), 32'd20);
    chk("t1_mismatch", {31'd0, mismatch}, 32'd0);
    chk("t1_ack", {31'd0, ch_ack}, 32'd0);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_queue", exp_q.size(), 32'd0);

    // 2: same stream, token 3 corrupted to 13
    lb_setup(5, 1'b1);
    for (int i = 0; i < 5; i++) push_exp(i, 1'b1, (i >= 3));
    pulse_start();
    chk("t2_done_low", {31'd0, done}, 32'd0);
    lb_en = 1'b1;
    wait_done(400);
    chk("t2_count", 32'(tok_count), 32'd5);
    chk("t2_mismatch", {31'd0, mismatch}, 32'd1);
    chk("t2_queue", exp_q.size(), 32'd0);

    // 3: request never released -> timeout in WAIT_REL
    lb_setup(0, 1'b0);
    timeout_limit = TW'(8);
    pulse_start();
    chk("t3_mismatch_clr", {31'd0, mismatch}, 32'd0);
    ch_data = '0;
    ch_req = 1'b1;
    push_exp(0, 1'b0, 1'b0);
    n = 0;
    while (ch_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ack_latency", n, SYNC + 1);
    repeat (7) @(negedge clk);
    chk("t3_timeout_early", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_ack", {31'd0, ch_ack}, 32'd0);
    chk("t3_count", 32'(tok_count), 32'd1);
    ch_req = 1'b0;
    timeout_limit = '0;
    repeat (4) @(negedge clk);

    // 4: no request, timeout disabled -> stuck in WAIT_REQ, start ignored
    burst_len = 16'd1;
    pulse_start();
    chk("t4_timeout_clr", {31'd0, timeout}, 32'd0);
    repeat (40) @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_count", 32'(tok_count), 32'd0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t4_busy_after_start", {31'd0, busy}, 32'd1);
    chk("t4_state", 32'(dbg_state), 32'd1);

    // 5: asynchronous reset in WAIT_REL
    ch_data = '0;
    ch_req = 1'b1;
    push_exp(0, 1'b0, 1'b0);
    n = 0;
    while (ch_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_ack_up", {31'd0, ch_ack}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_ack", {31'd0, ch_ack}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_count", 32'(tok_count), 32'd0);
    chk("t5_data", 32'(tok_data), 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    ch_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lb_setup(2, 1'b0);
    burst_len = 16'd2;
    push_exp(0, 1'b0, 1'b0);
    push_exp(1, 1'b0, 1'b0);
    pulse_start();
    lb_en = 1'b1;
    wait_done(300);
    chk("t5_restart_count", 32'(tok_count), 32'd2);
    chk("t5_restart_last", 32'(tok_data), 32'd2);
    chk("t5_restart_mismatch", {31'd0, mismatch}, 32'd0);

    // 6: unbounded burst of 300 tokens
    lb_setup(300, 1'b0);
    burst_len = 16'd0;
    for (int i = 0; i < 300; i++) push_exp(i, 1'b0, 1'b0);
    pulse_start();
    lb_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_queue", exp_q.size(), 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_count", 32'(tok_count), 32'd300);
    chk("t6_last", 32'(tok_data), 32'd89700);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_mismatch", {31'd0, mismatch}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
